// File: rtl/z80bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : z80bus_pkg
// Description : Shared command encodings, bus-state enum and phase constants
//               for the Z80-style bus initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package z80bus_pkg;

    localparam logic [2:0] CMD_M1   = 3'd0;
    localparam logic [2:0] CMD_MRD  = 3'd1;
    localparam logic [2:0] CMD_MWR  = 3'd2;
    localparam logic [2:0] CMD_IORD = 3'd3;
    localparam logic [2:0] CMD_IOWR = 3'd4;

    // Each T-state is split into a high phase followed by a low phase.
    localparam logic PH_H = 1'b0;
    localparam logic PH_L = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_TW   = 3'd3,
        ST_T3   = 3'd4,
        ST_T4   = 3'd5
    } bus_state_t;

    // Undefined encodings behave as a plain memory read.
    function automatic logic [2:0] norm_cmd(input logic [2:0] t);
        return (t > CMD_IOWR) ? CMD_MRD : t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/z80bus_rfsh.sv
`default_nettype none
// ============================================================================
// Module      : z80bus_rfsh
// Description : 7-bit refresh (R) counter and the refresh address mux.
//               Only instantiated when Z80BUS_REFRESH_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module z80bus_rfsh (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc,
    input  logic        i_sel,
    input  logic [7:0]  i_ireg,
    input  logic [15:0] i_addr,
    output logic [15:0] o_addr
);

    logic [6:0] r_r;

    // R advances once per completed opcode fetch, wrapping at 128.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_r <= 7'd0;
        end else if (i_inc) begin
            r_r <= r_r + 7'd1;
        end
    end

    assign o_addr = i_sel ? {i_ireg, 1'b0, r_r} : i_addr;

endmodule
`default_nettype wire

// File: rtl/z80_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : z80_bus_master
// Description : T-state accurate Z80-style bus initiator. Turns single
//               commands into MREQ/IOREQ/RD/WR/M1/RFSH strobe sequences and
//               honours n_WAIT. Optional refresh cycle support is enabled
//               with the Z80BUS_REFRESH_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module z80_bus_master
    import z80bus_pkg::*;
(
    input  logic        OSC,
    input  logic        RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_type,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    input  logic [7:0]  I_REG,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic [15:0] A,
    output logic [7:0]  D_out,
    output logic        D_oe,
    input  logic [7:0]  D_in,
    output logic        n_M1,
    output logic        n_MREQ,
    output logic        n_IOREQ,
    output logic        n_RD,
    output logic        n_WR,
    output logic        n_RFSH,
    input  logic        n_WAIT
);

    bus_state_t  r_state, w_state_nxt;
    logic        r_phase, w_phase_nxt;
    logic [2:0]  r_cmd;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_rsp_data;
    logic        w_capture;

    logic w_is_m1, w_is_io, w_is_rd;
    logic w_h, w_l, w_t1l, w_t2l, w_mid, w_t3h, w_t3l, w_t4h, w_t4l, w_t34;
    logic w_last, w_ready, w_accept;

    assign w_is_m1 = (r_cmd == CMD_M1);
    assign w_is_io = (r_cmd == CMD_IORD) || (r_cmd == CMD_IOWR);
    assign w_is_rd = (r_cmd == CMD_MRD)  || (r_cmd == CMD_IORD);

    assign w_h   = (r_phase == PH_H);
    assign w_l   = (r_phase == PH_L);
    assign w_t1l = (r_state == ST_T1) && w_l;
    assign w_t2l = (r_state == ST_T2) && w_l;
    assign w_mid = (r_state == ST_T2) || (r_state == ST_TW);
    assign w_t3h = (r_state == ST_T3) && w_h;
    assign w_t3l = (r_state == ST_T3) && w_l;
    assign w_t4h = (r_state == ST_T4) && w_h;
    assign w_t4l = (r_state == ST_T4) && w_l;
    assign w_t34 = (r_state == ST_T3) || (r_state == ST_T4);

    // The final L phase of a cycle can accept the next command directly.
    assign w_last   = w_is_m1 ? w_t4l : w_t3l;
    assign w_ready  = (r_state == ST_IDLE) || w_last;
    assign w_accept = cmd_valid && w_ready;

    // State, phase and captured command/response registers.
    always_ff @(posedge OSC) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_phase    <= PH_H;
            r_cmd      <= CMD_M1;
            r_addr     <= 16'h0000;
            r_wdata    <= 8'h00;
            r_rsp_data <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            if (w_accept) begin
                r_cmd   <= norm_cmd(cmd_type);
                r_addr  <= cmd_addr;
                r_wdata <= cmd_wdata;
            end
            if (w_capture) begin
                r_rsp_data <= D_in;
            end
        end
    end

    // Next state/phase, wait insertion and read-data capture strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_capture   = 1'b0;
        if (r_state == ST_IDLE) begin
            if (cmd_valid) begin
                w_state_nxt = ST_T1;
                w_phase_nxt = PH_H;
            end
        end else if (w_h) begin
            w_phase_nxt = PH_L;
            // MEM/IO reads latch data at the end of T3H.
            if ((r_state == ST_T3) && w_is_rd) begin
                w_capture = 1'b1;
            end
        end else begin
            w_phase_nxt = PH_H;
            case (r_state)
                ST_T1:   w_state_nxt = ST_T2;
                // IO always takes one TW; memory waits only if n_WAIT is low.
                ST_T2:   w_state_nxt = (w_is_io || !n_WAIT) ? ST_TW : ST_T3;
                ST_TW:   w_state_nxt = n_WAIT ? ST_T3 : ST_TW;
                ST_T3:   w_state_nxt = w_is_m1 ? ST_T4 : ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
            // Opcode fetch latches data when leaving the last T2L/TWL.
            if (w_is_m1 && w_mid && (w_state_nxt == ST_T3)) begin
                w_capture = 1'b1;
            end
            if (w_last && cmd_valid) begin
                w_state_nxt = ST_T1;
            end
        end
    end

`ifdef Z80BUS_REFRESH_EN
    logic w_rfsh_sel;
    assign w_rfsh_sel = w_is_m1 && w_t34;

    z80bus_rfsh u_rfsh (
        .clk    (OSC),
        .rst    (RST),
        .i_inc  (w_is_m1 && w_t4l),
        .i_sel  (w_rfsh_sel),
        .i_ireg (I_REG),
        .i_addr (r_addr),
        .o_addr (A)
    );
    assign n_RFSH = !w_rfsh_sel;
`else
    logic w_unused_ireg;
    assign w_unused_ireg = &{1'b0, I_REG};
    assign A      = r_addr;
    assign n_RFSH = 1'b1;
`endif

    // Strobe decode from the current state, phase and command.
    always_comb begin
        n_M1    = 1'b1;
        n_MREQ  = 1'b1;
        n_IOREQ = 1'b1;
        n_RD    = 1'b1;
        n_WR    = 1'b1;
        D_oe    = 1'b0;
        case (r_cmd)
            CMD_M1: begin
                n_M1   = !((r_state == ST_T1) || w_mid);
                n_RD   = !(w_t1l || w_mid);
`ifdef Z80BUS_REFRESH_EN
                n_MREQ = !(w_t1l || w_mid || w_t3l || w_t4h);
`else
                n_MREQ = !(w_t1l || w_mid);
`endif
            end
            CMD_MRD: begin
                n_MREQ = !(w_t1l || w_mid || w_t3h);
                n_RD   = !(w_t1l || w_mid || w_t3h);
            end
            CMD_MWR: begin
                n_MREQ = !(w_t1l || w_mid || w_t3h);
                n_WR   = !(w_t2l || (r_state == ST_TW) || w_t3h);
                D_oe   = w_t1l || w_mid || (r_state == ST_T3);
            end
            CMD_IORD: begin
                n_IOREQ = !(w_mid || w_t3h);
                n_RD    = !(w_mid || w_t3h);
            end
            CMD_IOWR: begin
                n_IOREQ = !(w_mid || w_t3h);
                n_WR    = !(w_mid || w_t3h);
                D_oe    = w_t1l || w_mid || (r_state == ST_T3);
            end
            default: begin
                n_M1 = 1'b1;
            end
        endcase
    end

    assign cmd_ready = w_ready && !RST;
    assign rsp_valid = !RST && ((w_is_m1 && w_t3h) || (w_is_rd && w_t3l));
    assign rsp_data  = r_rsp_data;
    assign D_out     = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_z80_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_z80_bus_master
// Description : Self-checking bench for z80_bus_master. Expected strobe
//               windows are derived from cycle positions within each command
//               (length, wait count), with a running model of R and the last
//               read byte. Refresh expectations follow Z80BUS_REFRESH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_z80_bus_master;

    logic        OSC = 1'b0;
    logic        RST = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_type = 3'd0;
    logic [15:0] cmd_addr = 16'h0;
    logic [7:0]  cmd_wdata = 8'h0;
    logic [7:0]  I_REG = 8'h0;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic [15:0] A;
    logic [7:0]  D_out;
    logic        D_oe;
    logic [7:0]  D_in = 8'h0;
    logic        n_M1, n_MREQ, n_IOREQ, n_RD, n_WR, n_RFSH;
    logic        n_WAIT = 1'b1;

    z80_bus_master dut (
        .OSC       (OSC),
        .RST       (RST),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_type  (cmd_type),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .I_REG     (I_REG),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .A         (A),
        .D_out     (D_out),
        .D_oe      (D_oe),
        .D_in      (D_in),
        .n_M1      (n_M1),
        .n_MREQ    (n_MREQ),
        .n_IOREQ   (n_IOREQ),
        .n_RD      (n_RD),
        .n_WR      (n_WR),
        .n_RFSH    (n_RFSH),
        .n_WAIT    (n_WAIT)
    );

    always #5 OSC = ~OSC;

    typedef struct packed {
        logic [2:0]  t;
        logic [15:0] addr;
        logic [7:0]  wd;
        logic [7:0]  rd;
        logic [7:0]  ireg;
        logic [1:0]  w;
        logic        b2b;
    } cmd_s;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] last_rd  = 8'h00;
    int         r_exp    = 0;
    cmd_s       q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic present(input cmd_s c);
        cmd_valid = 1'b1;
        cmd_type  = c.t;
        cmd_addr  = c.addr;
        cmd_wdata = c.wd;
    endtask

    task automatic check_idle();
        check_eq("idle_ready", cmd_ready, 1'b1);
        check_eq("idle_strobes", {n_M1, n_MREQ, n_IOREQ, n_RD, n_WR, n_RFSH}, 6'h3F);
        check_eq("idle_oe", D_oe, 1'b0);
        check_eq("idle_rsp_valid", rsp_valid, 1'b0);
        check_eq("idle_rsp_data", rsp_data, last_rd);
    endtask

    // Runs one command already presented in the current cycle.
    task automatic run_one(input cmd_s c, input bit has_next, input cmd_s nx);
        bit          is_m1, is_io, is_wr;
        int          w, len, rsp_k, smp_k, ws0;
        logic        e_m1, e_mreq, e_ioreq, e_rd, e_wr, e_rfsh, e_oe;
        logic [15:0] e_a;
        is_m1 = (c.t == 3'd0);
        is_io = (c.t == 3'd3) || (c.t == 3'd4);
        is_wr = (c.t == 3'd2) || (c.t == 3'd4);
        w     = int'(c.w);
        len   = (is_m1 || is_io) ? 8 + 2 * w : 6 + 2 * w;
        rsp_k = is_m1 ? len - 3 : (is_wr ? 0 : len);
        smp_k = rsp_k - 1;
        ws0   = is_io ? 6 : 4;
        @(posedge OSC); #1;
        I_REG = c.ireg;
        for (int k = 1; k <= len; k++) begin
            if (k > 1) begin
                @(posedge OSC); #1;
            end
            if (k >= ws0 && k <= ws0 + 2 * w && ((k - ws0) % 2 == 0))
                n_WAIT = (k == ws0 + 2 * w);
            else
                n_WAIT = 1'($urandom_range(0, 1));
            D_in = (k == smp_k) ? c.rd : 8'($urandom);
            if (k == len) begin
                if (has_next) present(nx);
                else cmd_valid = 1'b0;
            end else begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_type  = 3'($urandom);
                cmd_addr  = 16'($urandom);
                cmd_wdata = 8'($urandom);
            end
            if (rsp_k > 0 && k == rsp_k) last_rd = c.rd;

            e_m1 = 1'b1; e_mreq = 1'b1; e_ioreq = 1'b1; e_rd = 1'b1; e_wr = 1'b1;
            e_rfsh = 1'b1; e_a = c.addr;
            e_oe = is_wr && (k >= 2);
            if (is_m1) begin
                e_m1   = !(k <= 4 + 2 * w);
                e_mreq = !(k >= 2 && k <= 4 + 2 * w);
                e_rd   = e_mreq;
`ifdef Z80BUS_REFRESH_EN
                if (k == len - 2 || k == len - 1) e_mreq = 1'b0;
                if (k >= len - 3) begin
                    e_rfsh = 1'b0;
                    e_a    = {c.ireg, 1'b0, 7'(r_exp)};
                end
`endif
            end else if (is_io) begin
                e_ioreq = !(k >= 3 && k <= len - 1);
                if (is_wr) e_wr = e_ioreq;
                else       e_rd = e_ioreq;
            end else begin
                e_mreq = !(k >= 2 && k <= len - 1);
                if (is_wr) e_wr = !(k >= 4 && k <= len - 1);
                else       e_rd = e_mreq;
            end

            @(negedge OSC);
            if (!(is_m1 && k >= 5 && k <= 4 + 2 * w))
                check_eq("n_M1", n_M1, e_m1);
            check_eq("n_MREQ", n_MREQ, e_mreq);
            check_eq("n_IOREQ", n_IOREQ, e_ioreq);
            check_eq("n_RD", n_RD, e_rd);
            check_eq("n_WR", n_WR, e_wr);
            check_eq("n_RFSH", n_RFSH, e_rfsh);
            check_eq("A", A, e_a);
            check_eq("D_oe", D_oe, e_oe);
            if (e_oe) check_eq("D_out", D_out, c.wd);
            check_eq("rsp_valid", rsp_valid, (rsp_k > 0 && k == rsp_k));
            check_eq("rsp_data", rsp_data, last_rd);
            check_eq("cmd_ready", cmd_ready, (k == len));
        end
        if (is_m1) r_exp = (r_exp + 1) % 128;
        if (!has_next) begin
            @(posedge OSC); #1;
        end
    endtask

    task automatic run_queue();
        cmd_s nx;
        bit   hn;
        for (int i = 0; i < q.size(); i++) begin
            if (!(i > 0 && q[i].b2b)) begin
                present(q[i]);
                @(negedge OSC);
                check_idle();
            end
            hn = (i + 1 < q.size()) && q[i + 1].b2b;
            nx = hn ? q[i + 1] : q[i];
            run_one(q[i], hn, nx);
        end
        q.delete();
    endtask

    initial begin
        cmd_s c;
        // Reset state.
        repeat (3) @(posedge OSC);
        #1;
        @(negedge OSC);
        check_eq("rst_ready", cmd_ready, 1'b0);
        check_eq("rst_strobes", {n_M1, n_MREQ, n_IOREQ, n_RD, n_WR, n_RFSH}, 6'h3F);
        check_eq("rst_A", A, 16'h0000);
        check_eq("rst_D_out", D_out, 8'h00);
        check_eq("rst_D_oe", D_oe, 1'b0);
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_rsp_data", rsp_data, 8'h00);
        @(posedge OSC); #1;
        RST = 1'b0;
        @(negedge OSC);
        check_eq("rel_ready", cmd_ready, 1'b1);
        @(posedge OSC); #1;

        // Directed commands.
        q.push_back('{t: 3'd1, addr: 16'h4000, wd: 8'h00, rd: 8'hA5, ireg: 8'h00, w: 2'd0, b2b: 1'b0});
        q.push_back('{t: 3'd2, addr: 16'h5800, wd: 8'h3C, rd: 8'h00, ireg: 8'h00, w: 2'd2, b2b: 1'b0});
        q.push_back('{t: 3'd3, addr: 16'h00FE, wd: 8'h00, rd: 8'h1F, ireg: 8'h00, w: 2'd0, b2b: 1'b0});
        q.push_back('{t: 3'd0, addr: 16'h1234, wd: 8'h00, rd: 8'hC3, ireg: 8'h3F, w: 2'd0, b2b: 1'b0});
        q.push_back('{t: 3'd0, addr: 16'h1235, wd: 8'h00, rd: 8'h00, ireg: 8'h3F, w: 2'd0, b2b: 1'b1});
        q.push_back('{t: 3'd0, addr: 16'h1236, wd: 8'h00, rd: 8'h76, ireg: 8'h3F, w: 2'd0, b2b: 1'b1});
        run_queue();

        // Randomized commands, waits and back-to-back issue.
        for (int i = 0; i < 40; i++) begin
            c.t    = 3'($urandom);
            c.addr = 16'($urandom);
            c.wd   = 8'($urandom);
            c.rd   = 8'($urandom);
            c.ireg = 8'($urandom);
            c.w    = 2'($urandom_range(0, 2));
            c.b2b  = 1'($urandom_range(0, 1));
            q.push_back(c);
        end
        run_queue();

        // Reset during T2L of an IO write.
        c = '{t: 3'd4, addr: 16'h00FE, wd: 8'h55, rd: 8'h00, ireg: 8'h00, w: 2'd0, b2b: 1'b0};
        present(c);
        @(negedge OSC);
        check_idle();
        for (int k = 1; k <= 5; k++) begin
            @(posedge OSC); #1;
            cmd_valid = 1'b0;
            n_WAIT    = 1'b1;
            if (k == 4) RST = 1'b1;
            @(negedge OSC);
            if (k == 4) check_eq("abort_pre_nWR", n_WR, 1'b0);
        end
        check_eq("abort_strobes", {n_M1, n_MREQ, n_IOREQ, n_RD, n_WR, n_RFSH}, 6'h3F);
        check_eq("abort_D_oe", D_oe, 1'b0);
        check_eq("abort_rsp_valid", rsp_valid, 1'b0);
        check_eq("abort_ready", cmd_ready, 1'b0);
        @(posedge OSC); #1;
        RST = 1'b0;
        last_rd = 8'h00;
        r_exp   = 0;
        @(negedge OSC);
        check_eq("abort_rel_ready", cmd_ready, 1'b1);
        check_eq("abort_rel_rsp_valid", rsp_valid, 1'b0);
        check_eq("abort_rel_rsp_data", rsp_data, 8'h00);
        @(posedge OSC); #1;

        // Opcode fetch to 0x0038 after reset.
        q.push_back('{t: 3'd0, addr: 16'h0038, wd: 8'h00, rd: 8'hED, ireg: 8'h12, w: 2'd0, b2b: 1'b0});
        run_queue();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
